// File: rtl/harq_llr_combiner_pp.sv
// HARQ soft-combining engine: accumulates multi-lane LLR words into a circular
// buffer held in one of two ping-pong banks, with saturating per-lane adds and
// read-modify-write forwarding for back-to-back hits on the same address.
module harq_llr_combiner_pp #(
  parameter int unsigned LANES    = 16,
  parameter int unsigned LLR_IN_W = 6,
  parameter int unsigned ACC_W    = 10,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rst,
  input  logic                      i_start,
  input  logic [ADDR_W:0]           i_ncb_words,
  input  logic [CNT_W-1:0]          i_e_words,
  input  logic                      i_in_valid,
  input  logic [LANES*LLR_IN_W-1:0] i_in_data,
  output logic                      o_in_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_done_bank,
  output logic [ADDR_W:0]           o_valid_words,
  output logic [CNT_W-1:0]          o_sat_cnt,
  output logic [1:0]                o_bank_full,
  input  logic [1:0]                i_rd_release,
  input  logic                      i_rd_bank,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  output logic [LANES*ACC_W-1:0]    o_rd_data
);

  localparam int unsigned NCB_W  = ADDR_W + 1;
  localparam int unsigned IN_W   = LANES * LLR_IN_W;
  localparam int unsigned DATA_W = LANES * ACC_W;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITBANK,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NCB_W-1:0]   ncb_q, ncb_d;
  logic [CNT_W-1:0]   e_q, e_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               pass_q, pass_d;
  logic               drain_q, drain_d;
  logic               wr_bank_q, wr_bank_d;
  logic [1:0]         bank_full_q, bank_full_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_bank_q, done_bank_d;
  logic [NCB_W-1:0]   valid_words_q, valid_words_d;
  logic [CNT_W-1:0]   sat_cnt_q, sat_cnt_d;

  logic               accept;

  logic               s1_valid_q;
  logic [ADDR_W-1:0]  s1_addr_q;
  logic [IN_W-1:0]    s1_data_q;
  logic               s1_acc_q;
  logic               fwd_q;
  logic [DATA_W-1:0]  fwd_data_q;
  logic [DATA_W-1:0]  ram_rd_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic [DATA_W-1:0]  old_data;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_any_sat;

  logic [DATA_W-1:0]  mem0 [DEPTH];
  logic [DATA_W-1:0]  mem1 [DEPTH];

  assign accept = i_in_valid && in_ready_q;

  // Per-lane saturating add of the stage-1 input onto the forwarded or RAM value
  always_comb begin
    logic [LLR_IN_W-1:0] lane_in;
    logic [ACC_W-1:0]    lane_old;
    logic [SUM_W-1:0]    sum;
    lane_in    = '0;
    lane_old   = '0;
    sum        = '0;
    wr_data    = '0;
    wr_any_sat = 1'b0;
    old_data   = fwd_q ? fwd_data_q : ram_rd_q;
    for (int k = 0; k < LANES; k++) begin
      lane_in  = s1_data_q[k*LLR_IN_W +: LLR_IN_W];
      lane_old = s1_acc_q ? old_data[k*ACC_W +: ACC_W] : '0;
      sum = {{(SUM_W-LLR_IN_W){lane_in[LLR_IN_W-1]}}, lane_in} +
            {lane_old[ACC_W-1], lane_old};
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        wr_any_sat = 1'b1;
        wr_data[k*ACC_W +: ACC_W] = {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}};
      end else begin
        wr_data[k*ACC_W +: ACC_W] = sum[ACC_W-1:0];
      end
    end
  end

  // Next-state and control/output next values
  always_comb begin
    state_d       = state_q;
    ncb_d         = ncb_q;
    e_d           = e_q;
    acc_cnt_d     = acc_cnt_q;
    ptr_d         = ptr_q;
    pass_d        = pass_q;
    drain_d       = drain_q;
    wr_bank_d     = wr_bank_q;
    bank_full_d   = bank_full_q & ~i_rd_release;
    done_d        = 1'b0;
    done_bank_d   = done_bank_q;
    valid_words_d = valid_words_q;
    sat_cnt_d     = sat_cnt_q;

    if (s1_valid_q && wr_any_sat && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          ncb_d     = i_ncb_words;
          e_d       = i_e_words;
          acc_cnt_d = '0;
          ptr_d     = '0;
          pass_d    = 1'b0;
          sat_cnt_d = '0;
          if ((i_ncb_words == '0) || (i_e_words == '0)) begin
            state_d = S_DONE;
          end else if (bank_full_q[wr_bank_q]) begin
            state_d = S_WAITBANK;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_WAITBANK: begin
        if (!bank_full_q[wr_bank_q]) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CNT_W'(1);
          if (({1'b0, ptr_q} + NCB_W'(1)) == ncb_q) begin
            ptr_d  = '0;
            pass_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
          if (acc_cnt_d == e_q) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        if ((ncb_q != '0) && (e_q != '0)) begin
          bank_full_d[wr_bank_q] = 1'b1;
        end
        wr_bank_d = ~wr_bank_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) begin
      done_d        = 1'b1;
      done_bank_d   = wr_bank_q;
      valid_words_d = (e_d < CNT_W'(ncb_d)) ? NCB_W'(e_d) : ncb_d;
    end

    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_RUN) && (acc_cnt_d < e_d);
  end

  // Control state and registered outputs
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q       <= S_IDLE;
      ncb_q         <= '0;
      e_q           <= '0;
      acc_cnt_q     <= '0;
      ptr_q         <= '0;
      pass_q        <= 1'b0;
      drain_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      bank_full_q   <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_bank_q   <= 1'b0;
      valid_words_q <= '0;
      sat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ncb_q         <= ncb_d;
      e_q           <= e_d;
      acc_cnt_q     <= acc_cnt_d;
      ptr_q         <= ptr_d;
      pass_q        <= pass_d;
      drain_q       <= drain_d;
      wr_bank_q     <= wr_bank_d;
      bank_full_q   <= bank_full_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      done_bank_q   <= done_bank_d;
      valid_words_q <= valid_words_d;
      sat_cnt_q     <= sat_cnt_d;
    end
  end

  // Stage-1 valid and forward flag; forward when the word in flight hits the address now read
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      s1_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        fwd_q <= s1_valid_q && (s1_addr_q == ptr_q);
      end
    end
  end

  // Stage-1 payload captured on accept
  always_ff @(posedge i_core_clk) begin
    if (accept) begin
      s1_addr_q  <= ptr_q;
      s1_data_q  <= i_in_data;
      s1_acc_q   <= pass_q;
      fwd_data_q <= wr_data;
      ram_rd_q   <= wr_bank_q ? mem1[ptr_q] : mem0[ptr_q];
    end
  end

  // Bank write of the combined word
  always_ff @(posedge i_core_clk) begin
    if (s1_valid_q && !wr_bank_q) begin
      mem0[s1_addr_q] <= wr_data;
    end
    if (s1_valid_q && wr_bank_q) begin
      mem1[s1_addr_q] <= wr_data;
    end
  end

  // Readout port, one-cycle latency
  always_ff @(posedge i_core_clk) begin
    rd_data_q <= i_rd_bank ? mem1[i_rd_addr] : mem0[i_rd_addr];
  end

  assign o_in_ready    = in_ready_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_done_bank   = done_bank_q;
  assign o_valid_words = valid_words_q;
  assign o_sat_cnt     = sat_cnt_q;
  assign o_bank_full   = bank_full_q;
  assign o_rd_data     = rd_data_q;

endmodule

// File: tb/tb_harq_llr_combiner_pp.sv
// Directed bench for harq_llr_combiner_pp with hand-computed expectations.
module tb_harq_llr_combiner_pp;

  localparam int unsigned LANES    = 16;
  localparam int unsigned LLR_IN_W = 6;
  localparam int unsigned ACC_W    = 10;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IN_W     = LANES * LLR_IN_W;
  localparam int unsigned DATA_W   = LANES * ACC_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   ncb_words;
  logic [CNT_W-1:0]  e_words;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              done_bank;
  logic [ADDR_W:0]   valid_words;
  logic [CNT_W-1:0]  sat_cnt;
  logic [1:0]        bank_full;
  logic [1:0]        rd_release;
  logic              rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  harq_llr_combiner_pp #(
    .LANES(LANES), .LLR_IN_W(LLR_IN_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .i_core_clk   (clk),
    .i_rx_rst     (rst),
    .i_start      (start),
    .i_ncb_words  (ncb_words),
    .i_e_words    (e_words),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_done_bank  (done_bank),
    .o_valid_words(valid_words),
    .o_sat_cnt    (sat_cnt),
    .o_bank_full  (bank_full),
    .i_rd_release (rd_release),
    .i_rd_bank    (rd_bank),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] in_all(input int v);
    logic [IN_W-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) d[k*LLR_IN_W +: LLR_IN_W] = LLR_IN_W'(v);
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] acc_all(input int v);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) d[k*ACC_W +: ACC_W] = ACC_W'(v);
    return d;
  endfunction

  task automatic start_job(input int ncb, input int e);
    @(negedge clk);
    ncb_words = (ADDR_W+1)'(ncb);
    e_words   = CNT_W'(e);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_word(input logic [IN_W-1:0] d, input int gap);
    int guard;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("ready_timeout", DATA_W'(in_ready), DATA_W'(1));
    @(posedge clk);
  endtask

  task automatic finish_job(input string tag, input int exp_lat, input int exp_bank,
                            input int exp_vw, input int exp_sat, input int exp_full);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
    end while (!done && cyc < 1000);
    check({tag, "_done"},      DATA_W'(done),        DATA_W'(1));
    check({tag, "_latency"},   DATA_W'(cyc),         DATA_W'(exp_lat));
    check({tag, "_done_bank"}, DATA_W'(done_bank),   DATA_W'(exp_bank));
    check({tag, "_valid_w"},   DATA_W'(valid_words), DATA_W'(exp_vw));
    check({tag, "_sat_cnt"},   DATA_W'(sat_cnt),     DATA_W'(exp_sat));
    @(negedge clk);
    check({tag, "_done_pulse"}, DATA_W'(done),      DATA_W'(0));
    check({tag, "_bank_full"},  DATA_W'(bank_full), DATA_W'(exp_full));
  endtask

  task automatic read_word(input logic bank, input int addr, output logic [DATA_W-1:0] d);
    @(negedge clk);
    rd_bank = bank;
    rd_addr = ADDR_W'(addr);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic release_banks(input logic [1:0] v);
    @(negedge clk);
    rd_release = v;
    @(negedge clk);
    rd_release = 2'b00;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp;
    logic [IN_W-1:0]   w;
    logic              seen;

    rst = 1'b1; start = 1'b0; ncb_words = '0; e_words = '0;
    in_valid = 1'b0; in_data = '0; rd_release = 2'b00; rd_bank = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",    DATA_W'(in_ready),    DATA_W'(0));
    check("rst_busy",        DATA_W'(busy),        DATA_W'(0));
    check("rst_done",        DATA_W'(done),        DATA_W'(0));
    check("rst_done_bank",   DATA_W'(done_bank),   DATA_W'(0));
    check("rst_valid_words", DATA_W'(valid_words), DATA_W'(0));
    check("rst_sat_cnt",     DATA_W'(sat_cnt),     DATA_W'(0));
    check("rst_bank_full",   DATA_W'(bank_full),   DATA_W'(0));

    // Job 1: ncb=8, e=8, lane k = k-8, into bank0
    start_job(8, 8);
    check("j1_busy", DATA_W'(busy), DATA_W'(1));
    w = '0;
    for (int k = 0; k < LANES; k++) w[k*LLR_IN_W +: LLR_IN_W] = LLR_IN_W'(k - 8);
    for (int i = 0; i < 8; i++) send_word(w, 0);
    finish_job("j1", 3, 0, 8, 0, 1);
    exp = '0;
    for (int k = 0; k < LANES; k++) exp[k*ACC_W +: ACC_W] = ACC_W'(k - 8);
    read_word(1'b0, 0, d); check("j1_rd_a0", d, exp);
    read_word(1'b0, 7, d); check("j1_rd_a7", d, exp);

    // Job 2: ncb=4, e=12, all +5 with input gaps, into bank1
    start_job(4, 12);
    for (int i = 0; i < 12; i++) send_word(in_all(5), i % 2);
    finish_job("j2", 3, 1, 4, 0, 3);
    for (int a = 0; a < 4; a++) begin
      read_word(1'b1, a, d);
      check("j2_rd", d, acc_all(15));
    end
    read_word(1'b0, 3, d); check("j2_bank0_kept", d, exp);

    // Job 3: both banks full -> waits, then ncb=1 back-to-back forwarding into bank0
    start_job(1, 5);
    repeat (4) @(negedge clk);
    check("j3_wait_busy",  DATA_W'(busy),     DATA_W'(1));
    check("j3_wait_ready", DATA_W'(in_ready), DATA_W'(0));
    release_banks(2'b01);
    for (int i = 1; i <= 5; i++) send_word(IN_W'(i), 0);
    finish_job("j3", 3, 0, 1, 0, 3);
    exp = '0;
    exp[ACC_W-1:0] = ACC_W'(15);
    read_word(1'b0, 0, d); check("j3_fwd_a0", d, exp);

    // Job 4: positive saturation, ncb=2, e=200, all +31, into bank1
    release_banks(2'b11);
    check("rel_bank_full", DATA_W'(bank_full), DATA_W'(0));
    start_job(2, 200);
    for (int i = 0; i < 200; i++) send_word(in_all(31), 0);
    finish_job("j4", 3, 1, 2, 168, 2);
    read_word(1'b1, 0, d); check("j4_rd_a0", d, acc_all(511));
    read_word(1'b1, 1, d); check("j4_rd_a1", d, acc_all(511));

    // Job 5: negative saturation, ncb=2, e=40, all -32, into bank0
    start_job(2, 40);
    for (int i = 0; i < 40; i++) send_word(in_all(-32), 0);
    finish_job("j5", 3, 0, 2, 8, 3);
    read_word(1'b0, 1, d); check("j5_rd_a1", d, acc_all(-512));

    // Reset mid-RUN abandons the job
    release_banks(2'b10);
    start_job(8, 20);
    for (int i = 0; i < 3; i++) send_word(in_all(1), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",      DATA_W'(busy),      DATA_W'(0));
    check("mrst_bank_full", DATA_W'(bank_full), DATA_W'(0));
    check("mrst_in_ready",  DATA_W'(in_ready),  DATA_W'(0));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("mrst_no_done", DATA_W'(seen), DATA_W'(0));

    // Single-word job into bank0, then empty jobs leave flags alone
    start_job(1, 1);
    send_word(in_all(7), 0);
    finish_job("j7", 3, 0, 1, 0, 1);
    read_word(1'b0, 0, d); check("j7_rd_a0", d, acc_all(7));
    start_job(4, 0);
    finish_job("e0", 1, 1, 0, 0, 1);
    check("e0_busy", DATA_W'(busy), DATA_W'(0));
    start_job(0, 3);
    finish_job("n0", 1, done_bank, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
